// File: rtl/avalon_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// avalon_bus_arbiter_pkg
// Shared core bus types for the two-master / one-slave Avalon-MM arbiter:
//   avalon_req_t  - command from a master (read, write, address, data, BE)
//   avalon_resp_t - response to a master (readdata, readdatavalid, waitrequest)
//   state_t       - arbiter FSM states
//   req_active()  - a request is present when read or write is high
// ---------------------------------------------------------------------------
package avalon_bus_arbiter_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
  } avalon_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  function automatic logic req_active(input avalon_req_t r);
    return r.read | r.write;
  endfunction

endpackage

// File: rtl/avalon_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// avalon_bus_arbiter_if
// Bundles every bus signal around the arbiter.
//   m0_avalon_req/resp : requester 0 (instruction bus)
//   m1_avalon_req/resp : requester 1 (data bus, LSU)
//   s_avalon_req/resp  : shared memory port
//   busy               : arbiter is not in IDLE
//   state_dbg          : current FSM state, for observation only
// Modports:
//   slave  - the arbiter's view (it is the slave of both requesters)
//   master - the environment's view (requesters plus the memory model)
//
// Handshake: a command is transferred on a rising edge where read or write
// is high and waitrequest is low; the requester must hold the command stable
// while waitrequest is high. Read data returns later, qualified by
// readdatavalid, with at most one read outstanding.
// ---------------------------------------------------------------------------
interface avalon_bus_arbiter_if;
  import avalon_bus_arbiter_pkg::*;

  avalon_req_t  m0_avalon_req;
  avalon_resp_t m0_avalon_resp;
  avalon_req_t  m1_avalon_req;
  avalon_resp_t m1_avalon_resp;
  avalon_req_t  s_avalon_req;
  avalon_resp_t s_avalon_resp;
  logic         busy;
  state_t       state_dbg;

  modport slave (
    input  m0_avalon_req, m1_avalon_req, s_avalon_resp,
    output m0_avalon_resp, m1_avalon_resp, s_avalon_req, busy, state_dbg
  );

  modport master (
    output m0_avalon_req, m1_avalon_req, s_avalon_resp,
    input  m0_avalon_resp, m1_avalon_resp, s_avalon_req, busy, state_dbg
  );

endinterface

// File: rtl/avalon_bus_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-request priority pick, purely combinational.
//   req_i[1:0] : request per port
//   last_i     : index of the port granted last
//   gnt_o[1:0] : one-hot grant (all zero when nothing requests)
// With both requesting: RR_EN=1 grants the port not granted last,
// RR_EN=0 always grants port 0.
// ---------------------------------------------------------------------------
module rr_arbiter2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (RR_EN && !last_i) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_bus_arbiter
// Shares one Avalon-MM memory port between two requesters with zero added
// command latency and a single outstanding read.
//   clk, rst : clock and synchronous active-high reset
//   bus      : avalon_bus_arbiter_if.slave (m0/m1 request+response,
//              shared memory request+response, busy, state_dbg)
// Parameter RR_EN: 1 = round-robin tie break, 0 = fixed priority to port 0.
// FSM: IDLE (arbitrate), HOLD (command stalled, grant locked),
//      WAIT_RD (read accepted, waiting for readdatavalid).
// ---------------------------------------------------------------------------
module avalon_bus_arbiter
  import avalon_bus_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  avalon_bus_arbiter_if.slave bus
);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q,  last_d;

  logic [1:0]  req_vec;
  logic [1:0]  gnt;
  logic        grant_vld;
  logic        grant_idx;
  avalon_req_t fwd_req;

  // Only IDLE arbitrates; HOLD reuses the locked owner, WAIT_RD grants none.
  assign req_vec = (state_q == ST_IDLE)
                 ? {req_active(bus.m1_avalon_req), req_active(bus.m0_avalon_req)}
                 : 2'b00;

  rr_arbiter2 #(.RR_EN(RR_EN)) u_pick (
    .req_i  (req_vec),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign grant_vld = (state_q == ST_HOLD) | (|gnt);
  assign grant_idx = (state_q == ST_HOLD) ? owner_q : gnt[1];
  assign fwd_req   = !grant_vld ? '0
                   : (grant_idx ? bus.m1_avalon_req : bus.m0_avalon_req);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          owner_d = grant_idx;
          if (!bus.s_avalon_resp.waitrequest) begin
            last_d  = grant_idx;
            state_d = fwd_req.read ? ST_WAIT_RD : ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // If the owner illegally dropped its command, fwd_req is all-zero
        // and we still fall back to IDLE on the next non-stalled cycle.
        if (!bus.s_avalon_resp.waitrequest) begin
          if (req_active(fwd_req)) last_d = owner_q;
          state_d = fwd_req.read ? ST_WAIT_RD : ST_IDLE;
        end
      end
      ST_WAIT_RD: begin
        if (bus.s_avalon_resp.readdatavalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.s_avalon_req = fwd_req;

    bus.m0_avalon_resp.readdata      = bus.s_avalon_resp.readdata;
    bus.m1_avalon_resp.readdata      = bus.s_avalon_resp.readdata;
    bus.m0_avalon_resp.waitrequest   = (grant_vld && !grant_idx)
                                     ? bus.s_avalon_resp.waitrequest : 1'b1;
    bus.m1_avalon_resp.waitrequest   = (grant_vld && grant_idx)
                                     ? bus.s_avalon_resp.waitrequest : 1'b1;
    // readdatavalid outside WAIT_RD belongs to no live read and is dropped.
    bus.m0_avalon_resp.readdatavalid = (state_q == ST_WAIT_RD) && !owner_q
                                     && bus.s_avalon_resp.readdatavalid;
    bus.m1_avalon_resp.readdatavalid = (state_q == ST_WAIT_RD) && owner_q
                                     && bus.s_avalon_resp.readdatavalid;

    bus.busy      = (state_q != ST_IDLE);
    bus.state_dbg = state_q;
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avalon_bus_arbiter
// Directed bench for avalon_bus_arbiter. dut_rr (RR_EN=1) and dut_fx
// (RR_EN=0) see identical stimulus; inputs are driven 1 ns after the rising
// edge and outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_avalon_bus_arbiter;
  import avalon_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  avalon_bus_arbiter_if bus_rr ();
  avalon_bus_arbiter_if bus_fx ();

  assign bus_fx.m0_avalon_req = bus_rr.m0_avalon_req;
  assign bus_fx.m1_avalon_req = bus_rr.m1_avalon_req;
  assign bus_fx.s_avalon_resp = bus_rr.s_avalon_resp;

  avalon_bus_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr.slave));
  avalon_bus_arbiter #(.RR_EN(1'b0)) dut_fx (.clk(clk), .rst(rst), .bus(bus_fx.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv_m0(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus_rr.m0_avalon_req.read       = rd;
    bus_rr.m0_avalon_req.write      = wr;
    bus_rr.m0_avalon_req.address    = addr;
    bus_rr.m0_avalon_req.writedata  = data;
    bus_rr.m0_avalon_req.byteenable = 4'hF;
  endtask

  task automatic drv_m1(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus_rr.m1_avalon_req.read       = rd;
    bus_rr.m1_avalon_req.write      = wr;
    bus_rr.m1_avalon_req.address    = addr;
    bus_rr.m1_avalon_req.writedata  = data;
    bus_rr.m1_avalon_req.byteenable = 4'hF;
  endtask

  task automatic drv_s(input logic wait_r, input logic rvalid, input logic [31:0] rdata);
    bus_rr.s_avalon_resp.waitrequest   = wait_r;
    bus_rr.s_avalon_resp.readdatavalid = rvalid;
    bus_rr.s_avalon_resp.readdata      = rdata;
  endtask

  initial begin
    drv_m0(0, 0, 32'h0, 32'h0);
    drv_m1(0, 0, 32'h0, 32'h0);
    drv_s(0, 0, 32'h0);

    // ---- reset state
    rst = 1'b1;
    tick();
    settle();
    chk("rst_state", bus_rr.state_dbg, ST_IDLE);
    chk("rst_busy", bus_rr.busy, 1'b0);
    chk("rst_s_rdwr", {bus_rr.s_avalon_req.read, bus_rr.s_avalon_req.write}, 2'b00);
    chk("rst_rvalid", {bus_rr.m0_avalon_resp.readdatavalid, bus_rr.m1_avalon_resp.readdatavalid}, 2'b00);
    tick();
    rst = 1'b0;

    // ---- m1 write, accepted immediately
    drv_m1(0, 1, 32'h100, 32'hDEADBEEF);
    settle();
    chk("wr_s_write", bus_rr.s_avalon_req.write, 1'b1);
    chk("wr_s_addr", bus_rr.s_avalon_req.address, 32'h100);
    chk("wr_s_data", bus_rr.s_avalon_req.writedata, 32'hDEADBEEF);
    chk("wr_m1_wait", bus_rr.m1_avalon_resp.waitrequest, 1'b0);
    chk("wr_m0_wait", bus_rr.m0_avalon_resp.waitrequest, 1'b1);
    tick();
    drv_m1(0, 0, 32'h0, 32'h0);
    settle();
    chk("wr_state_idle", bus_rr.state_dbg, ST_IDLE);
    chk("wr_busy", bus_rr.busy, 1'b0);

    // ---- both read after reset: m0 first, then m1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv_m0(1, 0, 32'h10, 32'h0);
    drv_m1(1, 0, 32'h20, 32'h0);
    settle();
    chk("tie_s_read", bus_rr.s_avalon_req.read, 1'b1);
    chk("tie_s_addr_m0", bus_rr.s_avalon_req.address, 32'h10);
    chk("tie_m0_wait", bus_rr.m0_avalon_resp.waitrequest, 1'b0);
    chk("tie_m1_wait", bus_rr.m1_avalon_resp.waitrequest, 1'b1);
    tick();
    drv_m0(0, 0, 32'h0, 32'h0);
    settle();
    chk("wrd_state", bus_rr.state_dbg, ST_WAIT_RD);
    chk("wrd_busy", bus_rr.busy, 1'b1);
    chk("wrd_s_read", bus_rr.s_avalon_req.read, 1'b0);
    chk("wrd_m1_wait", bus_rr.m1_avalon_resp.waitrequest, 1'b1);
    chk("wrd_m0_rvalid_lo", bus_rr.m0_avalon_resp.readdatavalid, 1'b0);
    tick();
    drv_s(0, 1, 32'h12345678);
    settle();
    chk("rd0_m0_rvalid", bus_rr.m0_avalon_resp.readdatavalid, 1'b1);
    chk("rd0_m0_data", bus_rr.m0_avalon_resp.readdata, 32'h12345678);
    chk("rd0_m1_rvalid", bus_rr.m1_avalon_resp.readdatavalid, 1'b0);
    chk("rd0_m1_bcast", bus_rr.m1_avalon_resp.readdata, 32'h12345678);
    chk("rd0_s_read", bus_rr.s_avalon_req.read, 1'b0);
    tick();
    drv_s(0, 0, 32'h0);
    settle();
    chk("rd1_s_addr_m1", bus_rr.s_avalon_req.address, 32'h20);
    chk("rd1_s_read", bus_rr.s_avalon_req.read, 1'b1);
    chk("rd1_m1_wait", bus_rr.m1_avalon_resp.waitrequest, 1'b0);
    tick();
    drv_m1(0, 0, 32'h0, 32'h0);
    drv_s(0, 1, 32'hCAFEF00D);
    settle();
    chk("rd1_m1_rvalid", bus_rr.m1_avalon_resp.readdatavalid, 1'b1);
    chk("rd1_m0_rvalid", bus_rr.m0_avalon_resp.readdatavalid, 1'b0);
    tick();
    drv_s(0, 0, 32'h0);

    // ---- m0 read stalled 3 cycles while m1 waits
    drv_m0(1, 0, 32'h40, 32'h0);
    drv_m1(0, 1, 32'h44, 32'h55AA55AA);
    drv_s(1, 0, 32'h0);
    settle();
    chk("st1_s_addr", bus_rr.s_avalon_req.address, 32'h40);
    chk("st1_m0_wait", bus_rr.m0_avalon_resp.waitrequest, 1'b1);
    chk("st1_m1_wait", bus_rr.m1_avalon_resp.waitrequest, 1'b1);
    tick();
    settle();
    chk("st2_state", bus_rr.state_dbg, ST_HOLD);
    chk("st2_s_addr", bus_rr.s_avalon_req.address, 32'h40);
    chk("st2_m1_wait", bus_rr.m1_avalon_resp.waitrequest, 1'b1);
    tick();
    settle();
    chk("st3_state", bus_rr.state_dbg, ST_HOLD);
    chk("st3_s_addr", bus_rr.s_avalon_req.address, 32'h40);
    chk("st3_m1_wait", bus_rr.m1_avalon_resp.waitrequest, 1'b1);
    tick();
    drv_s(0, 0, 32'h0);
    settle();
    chk("st4_s_read", bus_rr.s_avalon_req.read, 1'b1);
    chk("st4_m0_wait", bus_rr.m0_avalon_resp.waitrequest, 1'b0);
    chk("st4_m1_wait", bus_rr.m1_avalon_resp.waitrequest, 1'b1);
    tick();
    drv_m0(0, 0, 32'h0, 32'h0);
    settle();
    chk("st5_state", bus_rr.state_dbg, ST_WAIT_RD);
    drv_s(0, 1, 32'hA5A5A5A5);
    settle();
    chk("st5_m0_rvalid", bus_rr.m0_avalon_resp.readdatavalid, 1'b1);
    tick();
    drv_s(0, 0, 32'h0);
    settle();
    chk("st6_s_write", bus_rr.s_avalon_req.write, 1'b1);
    chk("st6_s_addr", bus_rr.s_avalon_req.address, 32'h44);
    chk("st6_m1_wait", bus_rr.m1_avalon_resp.waitrequest, 1'b0);
    tick();
    drv_m1(0, 0, 32'h0, 32'h0);

    // ---- stray readdatavalid in IDLE is dropped
    drv_s(0, 1, 32'h11111111);
    settle();
    chk("idle_rvalid_drop", {bus_rr.m0_avalon_resp.readdatavalid, bus_rr.m1_avalon_resp.readdatavalid}, 2'b00);
    tick();
    drv_s(0, 0, 32'h0);

    // ---- requester drops its command in HOLD
    drv_m0(1, 0, 32'h60, 32'h0);
    drv_s(1, 0, 32'h0);
    tick();
    drv_m0(0, 0, 32'h0, 32'h0);
    settle();
    chk("drop_hold", bus_rr.state_dbg, ST_HOLD);
    chk("drop_s_read", bus_rr.s_avalon_req.read, 1'b0);
    tick();
    drv_s(0, 0, 32'h0);
    tick();
    settle();
    chk("drop_back_idle", bus_rr.state_dbg, ST_IDLE);

    // ---- reset in WAIT_RD, late readdatavalid dropped
    drv_m0(1, 0, 32'h70, 32'h0);
    tick();
    drv_m0(0, 0, 32'h0, 32'h0);
    settle();
    chk("rstw_state", bus_rr.state_dbg, ST_WAIT_RD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    drv_s(0, 1, 32'h22222222);
    settle();
    chk("rstw_idle", bus_rr.state_dbg, ST_IDLE);
    chk("rstw_busy", bus_rr.busy, 1'b0);
    chk("rstw_rvalid", {bus_rr.m0_avalon_resp.readdatavalid, bus_rr.m1_avalon_resp.readdatavalid}, 2'b00);
    tick();
    drv_s(0, 0, 32'h0);

    // ---- request in the WAIT_RD completion cycle: one bubble
    drv_m0(1, 0, 32'h70, 32'h0);
    tick();
    drv_m0(0, 0, 32'h0, 32'h0);
    drv_m1(1, 0, 32'h80, 32'h0);
    drv_s(0, 1, 32'h33333333);
    settle();
    chk("bub_s_read", bus_rr.s_avalon_req.read, 1'b0);
    chk("bub_m1_wait", bus_rr.m1_avalon_resp.waitrequest, 1'b1);
    tick();
    drv_s(0, 0, 32'h0);
    settle();
    chk("bub_next_read", bus_rr.s_avalon_req.read, 1'b1);
    chk("bub_next_addr", bus_rr.s_avalon_req.address, 32'h80);
    chk("bub_next_m1_wait", bus_rr.m1_avalon_resp.waitrequest, 1'b0);
    tick();
    drv_m1(0, 0, 32'h0, 32'h0);
    drv_s(0, 1, 32'h44444444);
    tick();
    drv_s(0, 0, 32'h0);

    // ---- continuous reads: round-robin alternates, fixed priority starves m1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv_m0(1, 0, 32'hA0, 32'h0);
    drv_m1(1, 0, 32'hB0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rr_addr", bus_rr.s_avalon_req.address, (k % 2 == 0) ? 32'hA0 : 32'hB0);
      chk("fx_addr", bus_fx.s_avalon_req.address, 32'hA0);
      chk("fx_m1_wait", bus_fx.m1_avalon_resp.waitrequest, 1'b1);
      tick();
      drv_s(0, 1, 32'h1000 + k);
      settle();
      chk("fx_m0_rvalid", bus_fx.m0_avalon_resp.readdatavalid, 1'b1);
      chk("fx_m1_rvalid", bus_fx.m1_avalon_resp.readdatavalid, 1'b0);
      chk("rr_m1_rvalid", bus_rr.m1_avalon_resp.readdatavalid, (k % 2 == 1) ? 1'b1 : 1'b0);
      tick();
      drv_s(0, 0, 32'h0);
    end
    drv_m0(0, 0, 32'h0, 32'h0);
    drv_m1(0, 0, 32'h0, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_bus_arbiter.md
AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

Interface
REQ-001 SHALL have parameter: RR_EN, 1, 1 = round-robin priority; 0 = fixed priority, port 0 wins.
REQ-002 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: m0_avalon_req  input  avalon_req_t  requester 0 (instruction bus): read, write, address[31:0], writedata[31:0], byteenable[3:0].
REQ-005 SHALL have port: m0_avalon_resp  output  avalon_resp_t  to requester 0: readdata[31:0], readdatavalid, waitrequest.
REQ-006 SHALL have port: m1_avalon_req  input  avalon_req_t  requester 1 (data bus, LSU).
REQ-007 SHALL have port: m1_avalon_resp  output  avalon_resp_t  to requester 1.
REQ-008 SHALL have port: s_avalon_req  output  avalon_req_t  shared memory port.
REQ-009 SHALL have port: s_avalon_resp  input  avalon_resp_t  from shared memory.
REQ-010 SHALL have port: busy  output  1  high when state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, HOLD (command presented, slave waitrequest=1), WAIT_RD (read accepted, awaiting readdatavalid).
REQ-012 In IDLE, a requester SHALL be active when read|write=1; with one requester active, it wins the grant combinationally in the same cycle.
REQ-013 With both active in IDLE: RR_EN=1 SHALL grant the port not granted last; RR_EN=0 SHALL grant port 0.
REQ-014 The granted request SHALL drive s_avalon_req in the same cycle (zero added latency); with no grant, s_avalon_req read/write SHALL be 0.
REQ-015 The granted port SHALL see waitrequest = s_avalon_resp.waitrequest; every non-granted port SHALL see waitrequest=1.
REQ-016 IDLE, granted command, slave waitrequest=0: write -> IDLE; read -> WAIT_RD.
REQ-017 IDLE, granted command, slave waitrequest=1 -> HOLD with grant locked; no re-arbitration until accepted.
REQ-018 HOLD SHALL forward the locked owner's request; on waitrequest=0, write -> IDLE, read -> WAIT_RD.
REQ-019 In WAIT_RD, s_avalon_req read/write SHALL be 0 and every port SHALL see waitrequest=1 (one outstanding read).
REQ-020 In WAIT_RD, s_avalon_resp readdata/readdatavalid SHALL be routed to the owner only; on readdatavalid=1 -> IDLE.
REQ-021 Non-owner readdatavalid SHALL always be 0; readdata SHALL be broadcast to both ports.
REQ-022 readdatavalid arriving in IDLE or HOLD SHALL be discarded.
REQ-023 The last-grant pointer SHALL update in the cycle a command is accepted (waitrequest=0), never on a stalled cycle.
REQ-024 A request arriving in the cycle WAIT_RD completes SHALL be arbitrated in the following IDLE cycle (one bubble).
REQ-025 A requester dropping read/write while in HOLD violates protocol; the arbiter SHALL still return to IDLE on the next waitrequest=0.

Reset
REQ-026 On rst: state=IDLE, owner=0, last-grant pointer=1 (port 0 wins first tie), busy=0.
REQ-027 During and after rst, s_avalon_req read/write SHALL be 0 until a request is seen in IDLE; m0/m1 readdatavalid=0.
REQ-028 Reset mid-transaction SHALL abandon the transaction; a late readdatavalid SHALL be dropped per REQ-022.

Structure
REQ-029 avalon_req_t, avalon_resp_t and the state enum SHALL live in the shared core package/header; the arbiter SHALL define no private bus types.
REQ-030 The priority pick SHALL be a sub-module rr_arbiter2 (2 requests, last-grant in, one-hot grant out); the FSM and muxing SHALL stay in avalon_bus_arbiter.

Verification
REQ-031 m1 write addr 0x100, data 0xDEADBEEF, slave waitrequest=0 -> s_avalon_req.write=1 same cycle, m1 waitrequest=0, state stays IDLE.
REQ-032 m0 and m1 read same cycle, RR_EN=1, after reset -> m0 granted; m1 next granted after m0 readdatavalid; m0 sees readdatavalid only with its data 0x12345678.
REQ-033 m0 read, slave waitrequest=1 for 3 cycles while m1 requests -> grant held on m0 (HOLD) 3 cycles, m1 waitrequest=1 throughout.
REQ-034 RR_EN=0, both hold reads continuously -> m0 granted every transaction, m1 starved.
REQ-035 rst asserted in WAIT_RD, readdatavalid arrives 2 cycles later -> state IDLE, no readdatavalid to m0 or m1.
REQ-036 readdatavalid and new m1 request in same WAIT_RD cycle -> m1 command on s_avalon_req exactly one cycle later.
